// File: rtl/tdm_demux.sv
// tdm_demux: receive side of the TDM link.
// Steers serial slot words into a parallel frame with valid/ack handoff.
module tdm_demux #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int SLOT_W   = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [WIDTH-1:0]          din,
    input  logic                      din_valid,
    input  logic                      sync,
    output logic [CHANNELS*WIDTH-1:0] dout,
    output logic                      frame_valid,
    input  logic                      frame_ack,
    output logic [SLOT_W-1:0]         slot,
    output logic                      sync_err,
    output logic                      overrun
);

    typedef enum logic {
        IDLE,
        RECV
    } state_t;

    localparam logic [SLOT_W-1:0] LAST = SLOT_W'(CHANNELS - 1);

    state_t                    state;
    logic [CHANNELS*WIDTH-1:0] cap;
    logic [CHANNELS*WIDTH-1:0] frame;
    logic                      take_sync;
    logic                      take_word;
    logic                      done;
    logic                      accept;

    // Decode this cycle's word and build the frame with the last word merged in.
    always_comb begin
        take_sync = din_valid && sync;
        take_word = din_valid && !sync && (state == RECV);
        done      = take_word && (slot == LAST);
        accept    = !frame_valid || frame_ack;
        frame     = cap;
        frame[(CHANNELS-1)*WIDTH +: WIDTH] = din;
    end

    // Slot tracking, capture buffer, and frame handoff to the consumer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            slot        <= '0;
            cap         <= '0;
            dout        <= '0;
            frame_valid <= 1'b0;
            sync_err    <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            sync_err <= 1'b0;
            if (take_sync) begin
                cap[WIDTH-1:0] <= din;
                slot           <= SLOT_W'(1);
                state          <= RECV;
                if (state == RECV && slot != '0)
                    sync_err <= 1'b1;
            end else if (take_word) begin
                cap[int'(slot)*WIDTH +: WIDTH] <= din;
                slot                           <= slot + SLOT_W'(1);
            end
            if (done) begin
                if (accept) begin
                    dout        <= frame;
                    frame_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (frame_valid && frame_ack) begin
                frame_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/tdm_demux.md
Name: tdm_demux

Overview:
- Receive-side counterpart of the lab's mux-based time-division transmit path.
- Accepts one time-multiplexed data word per valid cycle and steers each word into its channel slot.
- Presents a completed frame of CHANNELS words in parallel with a valid/acknowledge handshake.
- Sits between the serial TDM link and the per-channel consumer logic; the lab testbenches drive it with the existing mux/select network on the transmit side.

Parameters:
WIDTH, 8, bits per channel word
CHANNELS, 4, slots per frame (power of two, ≥2)
SLOT_W, 2, log2(CHANNELS); width of slot counter

Ports:
CLK  input  1  rising-edge clock
RST_N  input  1  asynchronous active-low reset
DIN  input  WIDTH  multiplexed data word
DIN_VALID  input  1  DIN carries a word this cycle
SYNC  input  1  qualifies DIN as slot 0 (frame start); meaningful only with DIN_VALID=1
DOUT  output  CHANNELS*WIDTH  completed frame; slot i at bits [i*WIDTH +: WIDTH]
FRAME_VALID  output  1  DOUT holds an unacknowledged frame
FRAME_ACK  input  1  consumer accepts DOUT; sampled only while FRAME_VALID=1
SLOT  output  SLOT_W  index the next accepted word will occupy
SYNC_ERR  output  1  one-cycle pulse: SYNC arrived mid-frame
OVERRUN  output  1  sticky: completed frame dropped because previous frame was unacknowledged

Behaviour:
- Reset is asynchronous and active-low: RST_N=0 forces the following immediately, independent of CLK:
  - state=IDLE, SLOT=0, capture buffer=0, DOUT=0
  - FRAME_VALID=0, SYNC_ERR=0, OVERRUN=0
- All other updates occur on the rising edge of CLK. Reset asserted mid-frame discards the partial frame and any pending unacknowledged frame.
- States:
  - IDLE: waiting for frame alignment. Words with DIN_VALID=1 and SYNC=0 are ignored; SLOT stays 0.
  - RECV: frame in progress.
- Word acceptance requires DIN_VALID=1. DIN_VALID=0 stalls the block: no slot advance and no buffer write. Stalls may be of any length.
- SYNC=1 with DIN_VALID=1, in any state:
  - DIN is written to buffer slot 0, SLOT becomes 1, state becomes RECV.
  - If the block was in RECV with SLOT≠0, the partial frame is discarded and SYNC_ERR=1 for exactly that cycle.
  - SYNC with SLOT=0 in RECV is legal, so back-to-back frames do not raise SYNC_ERR.
- In RECV, DIN_VALID=1 with SYNC=0 writes buffer slot SLOT, then SLOT increments.
- Frame completion: the edge that accepts slot CHANNELS-1 (without SYNC) completes the frame.
  - SLOT wraps to 0 and state stays RECV; the next word must carry SYNC, otherwise it is taken as slot 0 of an unaligned frame.
  - On the same edge, if FRAME_VALID=0, or FRAME_VALID=1 and FRAME_ACK=1: DOUT loads the full frame (the last word is merged directly, not taken from the buffer) and FRAME_VALID=1.
  - If FRAME_VALID=1 and FRAME_ACK=0: the new frame is dropped, DOUT and FRAME_VALID are held, and OVERRUN is set.
  - Latency: last word sampled at edge k; DOUT and FRAME_VALID are valid after edge k.
- Handshake: FRAME_ACK=1 while FRAME_VALID=1 clears FRAME_VALID on that edge, except when a new frame completes on the same edge, in which case FRAME_VALID stays 1 with new DOUT.
  - DOUT is stable while FRAME_VALID=1 and unacknowledged.
  - FRAME_ACK while FRAME_VALID=0 has no effect.
- OVERRUN clears only on reset.
- DOUT retains its last frame after acknowledge.
- Wrap arithmetic: SLOT is SLOT_W bits and rolls from CHANNELS-1 to 0 naturally.

Test Plan:
- Reset/IDLE: assert RST_N=0 mid-clock, then drive DIN=8'hAA with DIN_VALID=1 and SYNC=0 for 3 cycles → all outputs 0 immediately on reset; SLOT stays 0 and FRAME_VALID stays 0.
- Basic frame: SYNC+11, then 22, 33, 44 on consecutive cycles → after 4th edge DOUT=32'h44332211 and FRAME_VALID=1; FRAME_ACK one cycle → FRAME_VALID=0.
- Stalls: same frame with DIN_VALID=0 gaps of 1 and 3 cycles between words → identical DOUT; SLOT sequence 1,2,3,0 holds during gaps.
- Mid-frame SYNC: SYNC+01, 02, then SYNC+A1, A2, A3, A4 → SYNC_ERR pulses one cycle at A1; DOUT=32'hA4A3A2A1, with no trace of 01/02.
- Overrun vs simultaneous ack:
  - Two back-to-back frames with FRAME_ACK=0 → OVERRUN=1 and DOUT holds frame 1.
  - Repeat after reset with FRAME_ACK=1 on frame-2 completion edge → OVERRUN=0, FRAME_VALID=1, DOUT=frame 2.
- Reset mid-frame: accept 2 words, pulse RST_N=0, then send a full aligned frame → only the new frame appears; SLOT=0 during reset.
